vector_compare_sequencer: RTL

Multi-cycle initiator for the lane comparator `is_equal`. It accepts two packed operand vectors, drives one `is_equal` instance with one lane pair per cycle, and collects the per-lane results into a lane mask plus all-equal and any-equal summary flags. It sits between the vector register read stage and the branch/flag logic of the vector datapath.

---
 rtl/vec_pkg.sv | 14 +
 rtl/is_equal.sv | 16 +
 rtl/vector_compare_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector datapath units: default lane geometry
// and the comparison sequencer state encoding.
package vec_pkg;

   localparam int VEC_WIDTH = 32;
   localparam int VEC_LANES = 8;

   typedef enum logic [1:0] {
      CMP_IDLE    = 2'd0,
      CMP_COMPARE = 2'd1,
      CMP_REPORT  = 2'd2
   } cmp_state_t;

endpackage

// File: rtl/is_equal.sv
// Single-lane equality comparator. EQUAL is forced low while ENABLE is low
// so an idle comparator never reports a spurious match.
module is_equal #(
   parameter int WIDTH = 32
) (
   input  logic             ENABLE,
   input  logic [WIDTH-1:0] DATA_IN_1,
   input  logic [WIDTH-1:0] DATA_IN_2,
   output logic             EQUAL
);

   always_comb begin
      EQUAL = ENABLE && (DATA_IN_1 == DATA_IN_2);
   end

endmodule

// File: rtl/vector_compare_sequencer.sv
// Walks one is_equal comparator across all lanes of two latched operand
// vectors and reports a per-lane match mask plus all/any summary flags.
module vector_compare_sequencer
   import vec_pkg::*;
#(
   parameter int WIDTH = VEC_WIDTH,
   parameter int LANES = VEC_LANES
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   START,
   input  logic [LANES*WIDTH-1:0] VEC_A,
   input  logic [LANES*WIDTH-1:0] VEC_B,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [LANES-1:0]       MASK,
   output logic                   ALL_EQUAL,
   output logic                   ANY_EQUAL,
   output logic [1:0]             DEBUG_STATE
);

   localparam int IDX_W = $clog2(LANES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   localparam logic [1:0] S_IDLE    = CMP_IDLE;
   localparam logic [1:0] S_COMPARE = CMP_COMPARE;
   localparam logic [1:0] S_REPORT  = CMP_REPORT;

   logic [1:0]             state;
   logic [IDX_W-1:0]       idx;
   logic [LANES*WIDTH-1:0] op_a;
   logic [LANES*WIDTH-1:0] op_b;
   logic [WIDTH-1:0]       lane_a;
   logic [WIDTH-1:0]       lane_b;
   logic                   cmp_enable;
   logic                   lane_equal;
   logic [LANES-1:0]       next_mask;

   // Handshake: START is a request sampled only while BUSY is low; there is
   // no backpressure, and results are meaningful only in the single DONE cycle.
   assign BUSY        = (state != S_IDLE);
   assign DONE        = (state == S_REPORT);
   assign DEBUG_STATE = state;
   assign cmp_enable  = (state == S_COMPARE);

   // Lane select from the latched operands; zero outside COMPARE.
   always_comb begin
      lane_a = '0;
      lane_b = '0;
      for (int i = 0; i < LANES; i++) begin
         if (cmp_enable && (idx == IDX_W'(i))) begin
            lane_a = op_a[i*WIDTH +: WIDTH];
            lane_b = op_b[i*WIDTH +: WIDTH];
         end
      end
   end

   is_equal #(.WIDTH(WIDTH)) u_is_equal (
      .ENABLE    (cmp_enable),
      .DATA_IN_1 (lane_a),
      .DATA_IN_2 (lane_b),
      .EQUAL     (lane_equal)
   );

   always_comb begin
      next_mask = MASK | (LANES'(lane_equal) << idx);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         idx       <= '0;
         MASK      <= '0;
         ALL_EQUAL <= 1'b0;
         ANY_EQUAL <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (START) begin
                  op_a      <= VEC_A;
                  op_b      <= VEC_B;
                  idx       <= '0;
                  MASK      <= '0;
                  ALL_EQUAL <= 1'b0;
                  ANY_EQUAL <= 1'b0;
                  state     <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               MASK <= next_mask;
               // Flags come from the completed mask on the last-lane edge.
               if (idx == LAST_IDX) begin
                  ALL_EQUAL <= &next_mask;
                  ANY_EQUAL <= |next_mask;
                  state     <= S_REPORT;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_REPORT: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
